// File: rtl/box_motion_ctrl.sv
// Frame-synchronous motion scheduler and lowest-index pixel arbiter for up to NBOX bouncing boxes.
// Optional feature macro: BOX_MOTION_OVERRUN_EN adds overrun_cnt (count of ignored frame_start pulses).
module box_motion_ctrl #(
    parameter int NBOX   = 4,
    parameter int BOX_W  = 50,
    parameter int BOX_H  = 50,
    parameter int DRAW_W = 640,
    parameter int DRAW_H = 480
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        run,
    input  logic        cfg_we,
    input  logic [1:0]  cfg_idx,
    input  logic        cfg_en,
    input  logic [10:0] cfg_x,
    input  logic [9:0]  cfg_y,
    input  logic [3:0]  cfg_vx,
    input  logic [3:0]  cfg_vy,
    input  logic [10:0] pix_x,
    input  logic [9:0]  pix_y,
    output logic        pix_hit,
    output logic [1:0]  pix_id,
    output logic        busy,
    output logic        frame_done
`ifdef BOX_MOTION_OVERRUN_EN
,   output logic [7:0]  overrun_cnt
`endif
);

    localparam logic [10:0] X_LIM    = 11'(DRAW_W - BOX_W);
    localparam logic [10:0] Y_LIM    = 11'(DRAW_H - BOX_H);
    localparam logic [1:0]  LAST_IDX = 2'(NBOX - 1);

    typedef enum logic [1:0] {IDLE = 2'd0, UPDATE = 2'd1, DONE = 2'd2} state_t;
    typedef struct packed {
        logic [10:0] pos;
        logic [3:0]  vel;
    } axis_t;

    // -8 has no positive counterpart in 4 bits, so reflection saturates it to +7
    function automatic logic [3:0] neg_vel(input logic [3:0] v);
        if (v == 4'b1000) return 4'b0111;
        else              return 4'b0000 - v;
    endfunction

    function automatic axis_t axis_step(input logic [10:0] pos, input logic [3:0] vel,
                                        input logic [10:0] lim);
        logic signed [11:0] nxt;
        axis_t              res;
        nxt = $signed({1'b0, pos}) + $signed({{8{vel[3]}}, vel});
        if (nxt < 12'sd0) begin
            res.pos = 11'd0;
            res.vel = neg_vel(vel);
        end else if (nxt > $signed({1'b0, lim})) begin
            res.pos = lim;
            res.vel = neg_vel(vel);
        end else begin
            res.pos = nxt[10:0];
            res.vel = vel;
        end
        return res;
    endfunction

    function automatic logic [10:0] clamp(input logic [10:0] v, input logic [10:0] lim);
        return (v > lim) ? lim : v;
    endfunction

    state_t      state_r, state_nxt_s;
    logic [1:0]  idx_r, idx_nxt_s;
    logic [10:0] pos_x_r [NBOX];
    logic [10:0] pos_y_r [NBOX];
    logic [3:0]  vx_r    [NBOX];
    logic [3:0]  vy_r    [NBOX];
    logic [10:0] sx_r    [NBOX];
    logic [10:0] sy_r    [NBOX];
    logic [NBOX-1:0] en_r;
    axis_t       upd_x_s, upd_y_s;
    logic        hit_s;
    logic [1:0]  id_s;

    // Next-state logic; frame_start outside IDLE is dropped
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        case (state_r)
            IDLE: begin
                if (frame_start && run) begin
                    state_nxt_s = UPDATE;
                    idx_nxt_s   = 2'd0;
                end else if (frame_start) begin
                    state_nxt_s = DONE;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            UPDATE: begin
                if (idx_r == LAST_IDX) begin
                    state_nxt_s = DONE;
                end else begin
                    idx_nxt_s = idx_r + 2'd1;
                end
            end
            DONE:    state_nxt_s = IDLE;
            default: state_nxt_s = IDLE;
        endcase
    end

    // State register plus registered status outputs aligned with the state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            idx_r      <= 2'd0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            idx_r      <= idx_nxt_s;
            busy       <= (state_nxt_s == UPDATE);
            frame_done <= (state_nxt_s == DONE);
        end
    end

    // Shared update datapath for the box selected by idx_r
    always_comb begin
        upd_x_s = axis_step(pos_x_r[idx_r], vx_r[idx_r], X_LIM);
        upd_y_s = axis_step(pos_y_r[idx_r], vy_r[idx_r], Y_LIM);
    end

    // Working registers; a config write beats the same-cycle motion update
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NBOX; i++) begin
                pos_x_r[i] <= 11'd0;
                pos_y_r[i] <= 11'd0;
                vx_r[i]    <= 4'd1;
                vy_r[i]    <= 4'd1;
                en_r[i]    <= (i == 0);
            end
        end else begin
            for (int i = 0; i < NBOX; i++) begin
                if (cfg_we && (cfg_idx == 2'(i))) begin
                    pos_x_r[i] <= clamp(cfg_x, X_LIM);
                    pos_y_r[i] <= clamp({1'b0, cfg_y}, Y_LIM);
                    vx_r[i]    <= cfg_vx;
                    vy_r[i]    <= cfg_vy;
                    en_r[i]    <= cfg_en;
                end else if ((state_r == UPDATE) && (idx_r == 2'(i)) && en_r[i]) begin
                    pos_x_r[i] <= upd_x_s.pos;
                    pos_y_r[i] <= upd_y_s.pos;
                    vx_r[i]    <= upd_x_s.vel;
                    vy_r[i]    <= upd_y_s.vel;
                end
            end
        end
    end

    // Shadow copy used by the arbiter, refreshed once per frame
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NBOX; i++) begin
                sx_r[i] <= 11'd0;
                sy_r[i] <= 11'd0;
            end
        end else if (state_r == DONE) begin
            for (int i = 0; i < NBOX; i++) begin
                sx_r[i] <= pos_x_r[i];
                sy_r[i] <= pos_y_r[i];
            end
        end
    end

    // Descending scan so the lowest hitting index is the last one written
    always_comb begin
        hit_s = 1'b0;
        id_s  = 2'd0;
        for (int i = NBOX - 1; i >= 0; i--) begin
            logic h;
            h = en_r[i]
                && ({1'b0, pix_x} >= {1'b0, sx_r[i]})
                && ({1'b0, pix_x} <  ({1'b0, sx_r[i]} + 12'(BOX_W)))
                && ({2'b00, pix_y} >= {1'b0, sy_r[i]})
                && ({2'b00, pix_y} <  ({1'b0, sy_r[i]} + 12'(BOX_H)));
            hit_s = hit_s | h;
            id_s  = h ? 2'(i) : id_s;
        end
    end

    // Registered pixel result, one cycle behind pix_x/pix_y
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pix_hit <= 1'b0;
            pix_id  <= 2'd0;
        end else begin
            pix_hit <= hit_s;
            pix_id  <= id_s;
        end
    end

`ifdef BOX_MOTION_OVERRUN_EN
    // Saturating count of frame_start pulses dropped while busy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            overrun_cnt <= 8'd0;
        end else if (frame_start && (state_r != IDLE) && (overrun_cnt != 8'hFF)) begin
            overrun_cnt <= overrun_cnt + 8'd1;
        end
    end
`endif

endmodule
